// File: rtl/arb_pkg.sv
// Shared constants, state type and pointer helper for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDW   = 3;

    typedef enum logic [0:0] {
        IDLE,
        BUSY
    } arb_state_e;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] k);
        // Natural 3-bit wrap gives (k+1) mod 8.
        return k + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Requester-array / resource-side bundle for rr_arbiter_8.
interface rr_arbiter_8_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_prio_enc8.sv
// Rotating-priority 8:3 encoder: lowest set request at or above ptr, else lowest overall.
module rr_prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [IDW-1:0]   idx,
    output logic             found
);

    logic [N_REQ-1:0]   hi_mask;
    logic [2*N_REQ-1:0] dbl;

    // Low half holds only bits >= ptr; the upper half supplies the wrap-around candidates.
    assign hi_mask = 8'hFF << ptr;
    assign dbl     = {req, req & hi_mask};

    always_comb begin
        idx   = '0;
        found = 1'b1;
        casez (dbl)
            16'b????_????_????_???1: idx = 3'd0;
            16'b????_????_????_??10: idx = 3'd1;
            16'b????_????_????_?100: idx = 3'd2;
            16'b????_????_????_1000: idx = 3'd3;
            16'b????_????_???1_0000: idx = 3'd4;
            16'b????_????_??10_0000: idx = 3'd5;
            16'b????_????_?100_0000: idx = 3'd6;
            16'b????_????_1000_0000: idx = 3'd7;
            16'b????_???1_0000_0000: idx = 3'd0;
            16'b????_??10_0000_0000: idx = 3'd1;
            16'b????_?100_0000_0000: idx = 3'd2;
            16'b????_1000_0000_0000: idx = 3'd3;
            16'b???1_0000_0000_0000: idx = 3'd4;
            16'b??10_0000_0000_0000: idx = 3'd5;
            16'b?100_0000_0000_0000: idx = 3'd6;
            16'b1000_0000_0000_0000: idx = 3'd7;
            default: begin
                idx   = 3'd0;
                found = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with done/drop/hold-limit release and registered outputs.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic           clk,
    input logic           rst_n,
    rr_arbiter_8_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;

    logic [IDW-1:0]   enc_idx;
    logic             enc_found;
    logic             rel_done, rel_drop, rel_limit;

    rr_prio_enc8 u_enc (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (enc_idx),
        .found (enc_found)
    );

    assign rel_done  = bus.done;
    assign rel_drop  = ~bus.req[gnt_id_q];
    assign rel_limit = (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
                if (enc_found) begin
                    state_d     = BUSY;
                    gnt_d       = 8'b1 << enc_idx;
                    gnt_id_d    = enc_idx;
                    gnt_valid_d = 1'b1;
                    hold_d      = '0;
                    ptr_d       = next_ptr(enc_idx);
                end
            end
            BUSY: begin
                hold_d = hold_q + 8'd1;
                if (rel_done || rel_drop || rel_limit) begin
                    state_d     = IDLE;
                    hold_d      = '0;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    // Flag only releases forced purely by the hold limit.
                    timeout_d   = rel_limit && !rel_done && !rel_drop;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_q      <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Randomised and directed bench for rr_arbiter_8 against a grant-level reference model.
module tb_rr_arbiter_8;

    localparam int unsigned MaxHold = 16;

    logic clk = 1'b0;
    logic rst_n;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(MaxHold)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: who owns the resource, for how many visible cycles, and whose turn is next.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_to    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int j = 0; j < 8; j++) begin
            if (r[(p + j) % 8]) return (p + j) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_update(input logic [7:0] r, input logic d);
        int w;
        m_to = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_ptr   = (w + 1) % 8;
            end
        end else if (d || !r[m_owner] || m_held == int'(MaxHold)) begin
            m_to    = !d && r[m_owner] && (m_held == int'(MaxHold));
            m_owner = -1;
            m_held  = 0;
        end else begin
            m_held++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(bus.req, bus.done);
        @(negedge clk);
        chk("gnt", bus.gnt, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("gnt_id", bus.gnt_id, (m_owner >= 0) ? m_owner : 0);
        chk("gnt_valid", bus.gnt_valid, m_owner >= 0);
        chk("timeout", bus.timeout, m_to);
    endtask

    task automatic wait_grant(input string tag, input logic [2:0] exp_id);
        int n = 0;
        do begin
            step();
            n++;
        end while (!bus.gnt_valid && n < 40);
        chk(tag, {bus.gnt_valid, bus.gnt_id}, {1'b1, exp_id});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gcount, low, n;
        bit prev;

        rst_n    = 1'b0;
        bus.req  = 8'hFF;
        bus.done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_valid", bus.gnt_valid, 0);
        chk("rst_id", bus.gnt_id, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;

        // Full contention, done in the 3rd cycle of each grant.
        gcount = 0;
        low    = 0;
        prev   = 1'b0;
        for (int c = 0; c < 300 && gcount < 9; c++) begin
            bus.done = (m_owner >= 0) && (m_held == 3);
            step();
            if (bus.gnt_valid && !prev) begin
                chk("seq_id", bus.gnt_id, gcount % 8);
                if (gcount > 0) chk("turnaround", low, 1);
                gcount++;
                low = 0;
            end else if (!bus.gnt_valid) begin
                low++;
            end
            prev = bus.gnt_valid;
        end
        chk("seq_count", gcount, 9);

        // Wrap-around from ptr=7.
        bus.done = 1'b1;
        bus.req  = 8'h40;
        wait_grant("to6", 3'd6);
        bus.done = 1'b0;
        bus.req  = 8'b0000_0110;
        wait_grant("wrap_to1", 3'd1);
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        wait_grant("wrap_to2", 3'd2);

        // Hold-limit release.
        bus.req = 8'h10;
        wait_grant("to4", 3'd4);
        n = 1;
        step();
        while (bus.gnt == 8'h10 && n < 40) begin
            n++;
            step();
        end
        chk("hold_len", n, MaxHold);
        chk("timeout_pulse", {bus.timeout, bus.gnt}, {1'b1, 8'h00});
        step();
        chk("regrant4", {bus.gnt_valid, bus.gnt_id, bus.timeout}, {1'b1, 3'd4, 1'b0});

        // Early release by request drop.
        bus.req = 8'h08;
        wait_grant("to3", 3'd3);
        step();
        bus.req = 8'h00;
        step();
        chk("drop_release", {bus.gnt_valid, bus.timeout}, 2'b00);

        // done coinciding with the hold limit.
        bus.req = 8'h08;
        wait_grant("to3b", 3'd3);
        repeat (MaxHold - 1) step();
        bus.done = 1'b1;
        step();
        bus.done = 1'b0;
        chk("done_at_limit", {bus.gnt_valid, bus.timeout}, 2'b00);

        // Asynchronous reset mid-grant.
        bus.req = 8'h20;
        wait_grant("to5", 3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", bus.gnt, 0);
        chk("async_rst_valid", bus.gnt_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant("after_rst", 3'd5);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) bus.req = 8'($urandom);
            if ($urandom_range(7) == 0) bus.req = 8'h00;
            bus.done = ($urandom_range(5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one downstream resource between 8 requesters.
- Each grant uses an internal rotating-priority 8:3 encoder.
- A grant is held until the owner signals done, drops its request, or hits a hold-time limit.
- Sits between the requester array and the shared resource; gnt_id drives the resource's select mux.

Parameters:
- N, 8: number of requesters; fixed at 8 for this revision.
- IDW, 3: width of gnt_id; equals log2(N).
- MAX_HOLD, 16: maximum grant length in cycles before forced release; legal range 2..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  current owner finished; sampled only while gnt_valid=1.
- gnt  output  8  one-hot grant; all zero when no grant.
- gnt_id  output  3  index of granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Reset, asynchronous on rst_n low:
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0.
  - state=IDLE, ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- All outputs are registered.
- FSM states are IDLE and BUSY.
- IDLE:
  - If req!=0, select the winner k. k is the lowest set index >= ptr. If there is none, k is the lowest set index overall (wrap-around).
  - Next cycle: state=BUSY, gnt=1<<k, gnt_id=k, gnt_valid=1, hold_cnt=0, ptr=(k+1) mod 8.
  - If req==0, stay in IDLE with all outputs 0.
- Grant latency: a request sampled at edge t yields gnt_valid at edge t+1.
- BUSY:
  - hold_cnt increments each cycle.
  - Release condition, evaluated in this order: done=1, OR req[gnt_id]=0, OR hold_cnt==MAX_HOLD-1.
  - On release: next cycle state=IDLE, gnt=0, gnt_id=0, gnt_valid=0.
  - timeout=1 for that one cycle only if release was caused solely by the hold limit. If done or the request drop coincides with the limit, timeout=0.
- Turnaround: gnt_valid is low for exactly one cycle between consecutive grants, even with continuous requests.
- Fairness:
  - ptr advances only on grant issue.
  - With all 8 requesting continuously, grants cycle 0,1,...,7,0.
  - Max wait per requester is 7 grants.
- Requests from non-owners during BUSY are ignored. They are evaluated fresh in IDLE; no queuing.
- done while gnt_valid=0 is ignored.
- req bits may change at any time. Only the IDLE-cycle snapshot matters for selection.
- hold_cnt width is 8 bits and never wraps, because the release condition stops it at MAX_HOLD-1.
- No X on outputs after reset. There is no default-X case: the encoder default returns index 0 with found=0.

Decomposition:
- Shared package arb_pkg holds:
  - constants N_REQ=8, IDW=3;
  - state enum typedef {IDLE, BUSY};
  - a function for the next pointer, (k+1) mod N.
- One natural sub-module: rr_prio_enc8, combinational.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], found.
  - Implementation: a double-width masked casez scan giving ascending priority from ptr.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF -> gnt=0, gnt_valid=0. Release reset -> first grant is gnt=8'h01, gnt_id=0 one cycle after req is sampled.
- Full contention: req=8'hFF, done pulsed on the 3rd cycle of every grant -> gnt_id sequence 0,1,2,3,4,5,6,7,0. Exactly one gnt_valid=0 cycle between grants.
- Wrap-around: after a grant to 6 (ptr=7), apply req=8'b0000_0110 -> grant goes to 1, then ptr=2 and the next grant goes to 2.
- Timeout: MAX_HOLD=16, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 16 cycles, then timeout=1 for one cycle with gnt=0. A re-grant to 4 follows one cycle later.
- Early release: during grant to 3, drop req[3] while done=0 -> grant ends next cycle with timeout=0. Also done and the hold limit on the same cycle -> timeout=0.
- Async reset mid-grant: assert rst_n=0 between clock edges while gnt=8'h20 -> gnt=0 immediately. After release with req=8'h20, the grant returns to 5 (ptr back at 0, lowest set index >= 0 is 5).
